// File: rtl/bird_motion_ctrl.sv
// ---------------------------------------------------------------------------
// bird_motion_ctrl
//
// Vertical motion controller for the player bird. Keeps a fixed-point
// position (y_fp, FRAC_W fraction bits) and a signed fixed-point velocity,
// both advanced once per frame Tick while in Flight. Flap presses are
// edge-detected every clock and held until the next Tick. Position is clamped
// at the ceiling (0) and the floor (SCREEN_H-BIRD_H); each clamp zeroes the
// velocity and pulses HitCeil / HitFloor for one cycle.
//
// Optional build macro: FLOOR_STOP_EN
//   defined   - a floor clamp also moves Flight -> Stop (self game-over)
//   undefined - the floor only clamps; the bird rests there until flapped
//
// Ports
//   Clk, reset           clock, asynchronous active-high reset
//   Start, Stop, Ack     game-state controls (Initial->Flight, Flight->Stop,
//                        Stop->Initial)
//   Tick                 one-cycle frame-rate enable
//   BtnPress             debounced flap button level
//   Bird_X_L/R           constant horizontal box edges
//   Bird_Y_T/B           registered vertical box edges (integer pixels)
//   Velocity             signed two's complement, positive = downward
//   HitCeil/HitFloor     one-cycle clamp pulses
//   q_Initial/Flight/Stop one-hot state flags
// ---------------------------------------------------------------------------
module bird_motion_ctrl #(
   parameter int POS_W    = 10,
   parameter int FRAC_W   = 4,
   parameter int GRAVITY  = 8,
   parameter int JUMP_VEL = 96,
   parameter int TERM_VEL = 128,
   parameter int BIRD_W   = 20,
   parameter int BIRD_H   = 20,
   parameter int X_START  = 250,
   parameter int Y_START  = 220,
   parameter int SCREEN_H = 480
) (
   input  logic                      Clk,
   input  logic                      reset,
   input  logic                      Start,
   input  logic                      Stop,
   input  logic                      Ack,
   input  logic                      Tick,
   input  logic                      BtnPress,
   output logic [POS_W-1:0]          Bird_X_L,
   output logic [POS_W-1:0]          Bird_X_R,
   output logic [POS_W-1:0]          Bird_Y_T,
   output logic [POS_W-1:0]          Bird_Y_B,
   output logic [POS_W+FRAC_W-1:0]   Velocity,
   output logic                      HitCeil,
   output logic                      HitFloor,
   output logic                      q_Initial,
   output logic                      q_Flight,
   output logic                      q_Stop
);

   localparam int YW = POS_W + FRAC_W;

   // One bit wider than the stored values so sums never wrap before clamping.
   localparam logic signed [YW:0] GRAV_S  = (YW+1)'(GRAVITY);
   localparam logic signed [YW:0] JUMP_S  = (YW+1)'(JUMP_VEL);
   localparam logic signed [YW:0] TERM_S  = (YW+1)'(TERM_VEL);
   localparam logic signed [YW:0] FLOOR_S = (YW+1)'((SCREEN_H - BIRD_H) << FRAC_W);
   localparam logic [YW-1:0]      Y_RESET = YW'(Y_START << FRAC_W);
   localparam logic [POS_W-1:0]   TOP_RESET = POS_W'(Y_START);
   localparam logic [POS_W-1:0]   BOT_RESET = POS_W'(Y_START + BIRD_H);

   typedef enum logic [1:0] {
      ST_INITIAL,
      ST_FLIGHT,
      ST_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [YW-1:0]     y_q, y_d;
   logic [YW-1:0]     vel_q, vel_d;
   logic [POS_W-1:0]  top_q, top_d;
   logic [POS_W-1:0]  bot_q, bot_d;
   logic              flap_q, flap_d;
   logic              btn_q, btn_d;
   logic              hit_ceil_q, hit_ceil_d;
   logic              hit_floor_q, hit_floor_d;

   logic              flap_edge;
   logic              flap_now;
   logic signed [YW:0] vel_ext;
   logic signed [YW:0] v_fall;
   logic signed [YW:0] v_next;
   logic signed [YW:0] y_next;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_INITIAL;
         y_q         <= Y_RESET;
         vel_q       <= '0;
         top_q       <= TOP_RESET;
         bot_q       <= BOT_RESET;
         flap_q      <= 1'b0;
         btn_q       <= 1'b0;
         hit_ceil_q  <= 1'b0;
         hit_floor_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         vel_q       <= vel_d;
         top_q       <= top_d;
         bot_q       <= bot_d;
         flap_q      <= flap_d;
         btn_q       <= btn_d;
         hit_ceil_q  <= hit_ceil_d;
         hit_floor_q <= hit_floor_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      vel_d       = vel_q;
      flap_d      = flap_q;
      btn_d       = BtnPress;
      hit_ceil_d  = 1'b0;
      hit_floor_d = 1'b0;

      // A flap edge arriving in the Tick cycle itself still counts for that tick.
      flap_edge = BtnPress & ~btn_q;
      flap_now  = flap_q | flap_edge;

      // Semi-implicit Euler: the new velocity is applied to the position at once.
      vel_ext = {vel_q[YW-1], vel_q};
      v_fall  = vel_ext + GRAV_S;
      if (flap_now) begin
         v_next = -JUMP_S;
      end else if (v_fall > TERM_S) begin
         v_next = TERM_S;
      end else begin
         v_next = v_fall;
      end
      y_next = $signed({1'b0, y_q}) + v_next;

      case (state_q)
         ST_INITIAL: begin
            flap_d = 1'b0;
            if (Start) begin
               state_d = ST_FLIGHT;
            end
         end
         ST_FLIGHT: begin
            if (Stop) begin
               state_d = ST_STOP;
               flap_d  = 1'b0;
            end else if (Tick) begin
               flap_d = 1'b0;
               if (y_next[YW]) begin
                  y_d        = '0;
                  vel_d      = '0;
                  hit_ceil_d = 1'b1;
               end else if (y_next > FLOOR_S) begin
                  y_d         = FLOOR_S[YW-1:0];
                  vel_d       = '0;
                  hit_floor_d = 1'b1;
`ifdef FLOOR_STOP_EN
                  state_d     = ST_STOP;
`else
                  state_d     = ST_FLIGHT;
`endif
               end else begin
                  y_d   = y_next[YW-1:0];
                  vel_d = v_next[YW-1:0];
               end
            end else begin
               flap_d = flap_now;
            end
         end
         ST_STOP: begin
            flap_d = 1'b0;
            if (Ack) begin
               state_d = ST_INITIAL;
               y_d     = Y_RESET;
               vel_d   = '0;
            end
         end
         default: begin
            state_d = ST_INITIAL;
            flap_d  = 1'b0;
         end
      endcase

      // Box edges are registered alongside the position they come from.
      top_d = y_d[YW-1:FRAC_W];
      bot_d = top_d + POS_W'(BIRD_H);
   end

   assign Bird_X_L  = POS_W'(X_START);
   assign Bird_X_R  = POS_W'(X_START + BIRD_W);
   assign Bird_Y_T  = top_q;
   assign Bird_Y_B  = bot_q;
   assign Velocity  = vel_q;
   assign HitCeil   = hit_ceil_q;
   assign HitFloor  = hit_floor_q;
   assign q_Initial = (state_q == ST_INITIAL);
   assign q_Flight  = (state_q == ST_FLIGHT);
   assign q_Stop    = (state_q == ST_STOP);

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bird_motion_ctrl
//
// Drives bird_motion_ctrl with directed scenarios followed by random inputs
// and compares every output, every cycle, against a behavioural model built
// from the game rules with plain integer arithmetic. Honours FLOOR_STOP_EN.
// ---------------------------------------------------------------------------
module tb_bird_motion_ctrl;

   localparam int M_INIT   = 0;
   localparam int M_FLIGHT = 1;
   localparam int M_STOP   = 2;

   localparam int Y0       = 220 * 16;
   localparam int Y_LIMIT  = (480 - 20) * 16;
   localparam int G_ACC    = 8;
   localparam int J_VEL    = 96;
   localparam int T_VEL    = 128;

   logic        Clk;
   logic        reset;
   logic        Start;
   logic        Stop;
   logic        Ack;
   logic        Tick;
   logic        BtnPress;
   logic [9:0]  Bird_X_L;
   logic [9:0]  Bird_X_R;
   logic [9:0]  Bird_Y_T;
   logic [9:0]  Bird_Y_B;
   logic [13:0] Velocity;
   logic        HitCeil;
   logic        HitFloor;
   logic        q_Initial;
   logic        q_Flight;
   logic        q_Stop;

   int checkCount;
   int errorCount;

   int mMode;
   int mY;
   int mVel;
   bit mPending;
   bit mPrevBtn;
   bit mHitC;
   bit mHitF;

   bird_motion_ctrl dut (
      .Clk       (Clk),
      .reset     (reset),
      .Start     (Start),
      .Stop      (Stop),
      .Ack       (Ack),
      .Tick      (Tick),
      .BtnPress  (BtnPress),
      .Bird_X_L  (Bird_X_L),
      .Bird_X_R  (Bird_X_R),
      .Bird_Y_T  (Bird_Y_T),
      .Bird_Y_B  (Bird_Y_B),
      .Velocity  (Velocity),
      .HitCeil   (HitCeil),
      .HitFloor  (HitFloor),
      .q_Initial (q_Initial),
      .q_Flight  (q_Flight),
      .q_Stop    (q_Stop)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Counts one comparison and reports it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reset values of the behavioural model.
   task automatic modelReset();
      mMode    = M_INIT;
      mY       = Y0;
      mVel     = 0;
      mPending = 1'b0;
      mPrevBtn = 1'b0;
      mHitC    = 1'b0;
      mHitF    = 1'b0;
   endtask

   // One clock of the game rules, given the inputs present at that clock edge.
   task automatic modelStep(input bit start, input bit stop, input bit ack,
                            input bit tick, input bit btn);
      bit pressed;
      int v;
      int yn;
      pressed  = btn && !mPrevBtn;
      mPrevBtn = btn;
      mHitC    = 1'b0;
      mHitF    = 1'b0;
      if (mMode == M_INIT) begin
         mPending = 1'b0;
         if (start) mMode = M_FLIGHT;
      end else if (mMode == M_FLIGHT) begin
         if (stop) begin
            mMode    = M_STOP;
            mPending = 1'b0;
         end else if (tick) begin
            if (mPending || pressed) v = -J_VEL;
            else if (mVel + G_ACC > T_VEL) v = T_VEL;
            else v = mVel + G_ACC;
            yn = mY + v;
            if (yn < 0) begin
               mY = 0; mVel = 0; mHitC = 1'b1;
            end else if (yn > Y_LIMIT) begin
               mY = Y_LIMIT; mVel = 0; mHitF = 1'b1;
`ifdef FLOOR_STOP_EN
               mMode = M_STOP;
`endif
            end else begin
               mY = yn; mVel = v;
            end
            mPending = 1'b0;
         end else begin
            mPending = mPending || pressed;
         end
      end else begin
         mPending = 1'b0;
         if (ack) begin
            mMode = M_INIT; mY = Y0; mVel = 0;
         end
      end
   endtask

   task automatic compareAll();
      logic [13:0] expVel;
      expVel = 14'(mVel);
      checkOutput("x_l", 32'(Bird_X_L), 32'd250);
      checkOutput("x_r", 32'(Bird_X_R), 32'd270);
      checkOutput("y_t", 32'(Bird_Y_T), 32'(mY / 16));
      checkOutput("y_b", 32'(Bird_Y_B), 32'(mY / 16 + 20));
      checkOutput("velocity", 32'(Velocity), 32'(expVel));
      checkOutput("hit_ceil", 32'(HitCeil), 32'(mHitC));
      checkOutput("hit_floor", 32'(HitFloor), 32'(mHitF));
      checkOutput("q_initial", 32'(q_Initial), 32'(mMode == M_INIT));
      checkOutput("q_flight", 32'(q_Flight), 32'(mMode == M_FLIGHT));
      checkOutput("q_stop", 32'(q_Stop), 32'(mMode == M_STOP));
   endtask

   // Drives one cycle of inputs, then samples 1 ns after the clock edge.
   task automatic applyStimulus(input bit start, input bit stop, input bit ack,
                                input bit tick, input bit btn);
      Start    = start;
      Stop     = stop;
      Ack      = ack;
      Tick     = tick;
      BtnPress = btn;
      @(posedge Clk);
      #1;
      modelStep(start, stop, ack, tick, btn);
      compareAll();
   endtask

   // Asserts reset part-way through a cycle and checks the asynchronous effect.
   task automatic doReset(input int delay);
      Start = 1'b0; Stop = 1'b0; Ack = 1'b0; Tick = 1'b0; BtnPress = 1'b0;
      #delay;
      reset = 1'b1;
      #1;
      modelReset();
      compareAll();
      @(posedge Clk);
      #1;
      reset = 1'b0;
      compareAll();
   endtask

   // Back to Initial with reset-value motion, then into Flight.
   task automatic restartFlight();
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
   endtask

   initial begin
      int ticks;
      int yHold;
      int expV[3];
      int expY[3];
      bit btnLevel;
      checkCount = 0;
      errorCount = 0;
      reset = 1'b0;
      Start = 1'b0; Stop = 1'b0; Ack = 1'b0; Tick = 1'b0; BtnPress = 1'b0;
      modelReset();
      doReset(2);

      // Start together with Tick: no motion on that tick.
      applyStimulus(1, 0, 0, 1, 0);
      expV = '{8, 16, 24};
      expY = '{220, 221, 223};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 1, 0);
         checkOutput("fall_vel", 32'(Velocity), 32'(expV[i]));
         checkOutput("fall_y", 32'(Bird_Y_T), 32'(expY[i]));
      end

      // Two edges before one tick give a single flap.
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("flap_vel", 32'(Velocity), 32'(14'h3FA0));
      checkOutput("flap_y", 32'(Bird_Y_T), 32'd217);

      // Free fall from rest saturates at terminal velocity from tick 16.
      restartFlight();
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 1, 0);
         if (i >= 16) checkOutput("term_vel", 32'(Velocity), 32'd128);
      end

      // Flap every frame from the start height until the ceiling clamps.
      restartFlight();
      ticks = 0;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         applyStimulus(0, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 1, 0);
         ticks++;
         if (HitCeil) break;
      end
      checkOutput("ceil_tick", 32'(ticks), 32'd37);
      checkOutput("ceil_y", 32'(Bird_Y_T), 32'd0);
      checkOutput("ceil_vel", 32'(Velocity), 32'd0);
      applyStimulus(0, 0, 0, 0, 0);

      // Free fall down to the floor.
      ticks = 0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
         ticks++;
         if (HitFloor) break;
      end
      checkOutput("floor_pulse", 32'(HitFloor), 32'd1);
      checkOutput("floor_y_t", 32'(Bird_Y_T), 32'd460);
      checkOutput("floor_y_b", 32'(Bird_Y_B), 32'd480);
      applyStimulus(0, 0, 0, 0, 0);
`ifdef FLOOR_STOP_EN
      checkOutput("floor_stop", 32'(q_Stop), 32'd1);
`else
      checkOutput("floor_stay", 32'(q_Flight), 32'd1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("floor_rest", 32'(Bird_Y_T), 32'd460);
`endif

      // Stop coincident with Tick: no motion, then Ack reloads.
      yHold = 32'(Bird_Y_T);
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput("stop_tick_y", 32'(Bird_Y_T), 32'(yHold));
      checkOutput("stop_tick_q", 32'(q_Stop), 32'd1);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("ack_q", 32'(q_Initial), 32'd1);
      checkOutput("ack_y", 32'(Bird_Y_T), 32'd220);
      checkOutput("ack_vel", 32'(Velocity), 32'd0);

      // Reset in mid-flight.
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, (i == 2));
      doReset(3);
      checkOutput("rst_y", 32'(Bird_Y_T), 32'd220);
      checkOutput("rst_q", 32'(q_Initial), 32'd1);

      // Random traffic.
      btnLevel = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 799) == 0) begin
            doReset(3);
            btnLevel = 1'b0;
         end else begin
            if ($urandom_range(0, 2) == 0) btnLevel = ~btnLevel;
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                          btnLevel);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
- Parametrised successor to the single-bird flight controller.
- Computes bird vertical motion with signed fixed-point velocity and sub-pixel position, updated once per frame tick rather than every clock.
- Edge-detects and latches the flap button between ticks, clamps at ceiling and floor with hit pulses, and applies a terminal velocity.
- Sits between the button debouncer, the game-state controller (Start/Stop/Ack) and the VGA renderer/collision logic, which consume the bird box.

Parameters:
- POS_W, 10, pixel coordinate width.
- FRAC_W, 4, sub-pixel fraction bits of position/velocity.
- GRAVITY, 8, velocity increment per tick (fixed-point, 8 = 0.5 px/tick²).
- JUMP_VEL, 96, upward speed loaded on flap (fixed-point, 96 = 6 px/tick).
- TERM_VEL, 128, maximum downward speed (fixed-point, 128 = 8 px/tick).
- BIRD_W, 20, bird width in pixels.
- BIRD_H, 20, bird height in pixels.
- X_START, 250, bird left edge.
- Y_START, 220, bird top edge at start.
- SCREEN_H, 480, visible lines; floor limit for Bird_Y_B.

Ports:
- Clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- Start, in, 1, leave Initial.
- Stop, in, 1, game over request.
- Ack, in, 1, acknowledge game over.
- Tick, in, 1, one-cycle frame-rate enable.
- BtnPress, in, 1, debounced flap button (level).
- Bird_X_L, out, POS_W, bird left edge.
- Bird_X_R, out, POS_W, bird right edge.
- Bird_Y_T, out, POS_W, bird top edge (integer part of position).
- Bird_Y_B, out, POS_W, bird bottom edge.
- Velocity, out, POS_W+FRAC_W, signed two's complement; positive = downward.
- HitCeil, out, 1, one-cycle pulse on ceiling clamp.
- HitFloor, out, 1, one-cycle pulse on floor clamp.
- q_Initial, out, 1, one-hot state flag.
- q_Flight, out, 1, one-hot state flag.
- q_Stop, out, 1, one-hot state flag.

Behaviour:
- Reset (async, active-high):
  - State = Initial (q_Initial=1).
  - y_fp = Y_START<<FRAC_W; Velocity = 0; HitCeil = HitFloor = 0; flap pending = 0; button history = 0.
- Bird_X_L = X_START and Bird_X_R = X_START+BIRD_W, constant at all times.
- Bird_Y_T = y_fp>>FRAC_W (truncate); Bird_Y_B = Bird_Y_T+BIRD_H. Both are registered outputs.
- States and transitions:
  - Initial → Flight on Start. Position and velocity are held at reset values while in Initial.
  - Flight → Stop on Stop.
  - Stop → Initial on Ack; position and velocity are reloaded on that transition.
  - Stop freezes position and velocity.
- Flap detection:
  - BtnPress rising edge (registered history) sets flap pending, in Flight only.
  - Edges in Initial or Stop are discarded, and pending is cleared on leaving Flight.
  - Multiple edges between ticks count as one flap.
- Update on Tick in Flight (single cycle, semi-implicit Euler):
  - v_next = -JUMP_VEL if flap pending, else min(Velocity+GRAVITY, TERM_VEL).
  - y_next = y_fp + v_next, computed one bit wider and signed.
  - Flap pending is cleared.
- Ceiling clamp: if y_next < 0 → y_fp = 0, Velocity = 0, HitCeil = 1 for one cycle.
- Floor clamp: if y_next > (SCREEN_H-BIRD_H)<<FRAC_W → y_fp = that limit, Velocity = 0, HitFloor = 1 for one cycle.
- Otherwise y_fp = y_next and Velocity = v_next.
- Latency: outputs reflect a tick one cycle after the Tick cycle.
- Simultaneous events:
  - Stop and Tick in the same cycle: Stop wins, no motion update.
  - Start and Tick in the same cycle: no motion update; motion begins on the next tick.
  - Flap edge coincident with Tick: the flap applies on that tick.
- Reset mid-flight: immediate return to all reset values.

Optional Feature:
- FLOOR_STOP_EN
  - Defined: a floor clamp also moves the state Flight → Stop in the same cycle HitFloor is asserted (self game-over).
  - Undefined: the floor only clamps and pulses HitFloor; the bird rests on the floor until flapped, and only Stop leaves Flight.

Test Plan:
- Reset, Start, no button, 3 ticks → Velocity 8/16/24; Bird_Y_T 220/221/223; Bird_Y_B = Bird_Y_T+20.
- Flight, BtnPress pulse mid-frame, then tick → Velocity = -96, Bird_Y_T falls by 6; second edge before the same tick has no extra effect.
- Free fall of 20 ticks → Velocity saturates at 128 from tick 16 and stays at 128.
- Flap edge every frame from 220 → Bird_Y_T clamps to 0 on tick 37, HitCeil high exactly one cycle, Velocity = 0.
- Free fall to floor → Bird_Y_T = 460, Bird_Y_B = 480, HitFloor one-cycle pulse; with FLOOR_STOP_EN, q_Stop = 1 in the next cycle.
- Stop together with Tick → no position change, q_Stop = 1.
  - Then Ack → q_Initial = 1, Bird_Y_T = 220, Velocity = 0.
  - Then assert reset mid-flight → immediate reset values.
